// File: rtl/fetch_decode_queue_pkg.sv
// Shared field layout for the fetch/decode queue.
// Opcode and register-address widths, bit positions, NOP opcode.
package fetch_decode_queue_pkg;

  localparam int OPC_W    = 4;
  localparam int REG_W    = 2;
  localparam int REG1_LSB = 2;
  localparam int REG2_LSB = 0;

  typedef logic [OPC_W-1:0] opcode_t;
  typedef logic [REG_W-1:0] reg_addr_t;

  localparam opcode_t NOP_OPC = 4'h0;

endpackage

// File: rtl/fetch_decode_queue_ptr.sv
// queue_ptr: wrap-around pointer with increment and clear.
// Ports: clk, rst (async active-low), clr, inc, ptr.
module queue_ptr #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // DEPTH is a power of two, so natural overflow wraps
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode FIFO presenting decoded head fields, NOP when empty.
// Ports: clk, rst, Flush, in_valid/in_ready, fetch fields, out_valid/out_ready, decode fields, count.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] Instruction,
  input  logic [DATA_W-1:0] Next_PC,
  input  logic [DATA_W-1:0] IN_Port,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPC_W-1:0]  Opcode,
  output logic [REG_W-1:0]  Read_Reg_1,
  output logic [REG_W-1:0]  Read_Reg_2,
  output logic [DATA_W-1:0] Imm,
  output logic [DATA_W-1:0] Next_PC_out,
  output logic [DATA_W-1:0] IN_Port_out,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [DATA_W-1:0] npc_mem   [DEPTH];
  logic [DATA_W-1:0] port_mem  [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push;
  logic             pop;

  logic [DATA_W-1:0] head_instr;
  logic [DATA_W-1:0] head_npc;
  logic [DATA_W-1:0] head_port;

  // Ready/valid come from count_q only; no path from out_ready
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);

  assign push = in_valid && in_ready && !Flush;
  assign pop  = out_valid && out_ready && !Flush;

  queue_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (Flush),
    .inc (pop),
    .ptr (rd_ptr)
  );

  queue_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (Flush),
    .inc (push),
    .ptr (wr_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (Flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is not reset: outputs are masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= Instruction;
      npc_mem[wr_ptr]   <= Next_PC;
      port_mem[wr_ptr]  <= IN_Port;
    end
  end

  assign head_instr = instr_mem[rd_ptr];
  assign head_npc   = npc_mem[rd_ptr];
  assign head_port  = port_mem[rd_ptr];

  assign Opcode      = out_valid ? head_instr[DATA_W-1 -: OPC_W] : NOP_OPC;
  assign Read_Reg_1  = out_valid ? head_instr[REG1_LSB +: REG_W] : '0;
  assign Read_Reg_2  = out_valid ? head_instr[REG2_LSB +: REG_W] : '0;
  assign Imm         = out_valid ? head_instr : '0;
  assign Next_PC_out = out_valid ? head_npc : '0;
  assign IN_Port_out = out_valid ? head_port : '0;
  assign count       = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue.
// Drives on falling edge, samples on falling edge before redriving.
module tb_fetch_decode_queue;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              Flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] Instruction = '0;
  logic [DATA_W-1:0] Next_PC = '0;
  logic [DATA_W-1:0] IN_Port = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [3:0]        Opcode;
  logic [1:0]        Read_Reg_1;
  logic [1:0]        Read_Reg_2;
  logic [DATA_W-1:0] Imm;
  logic [DATA_W-1:0] Next_PC_out;
  logic [DATA_W-1:0] IN_Port_out;
  logic [CNT_W-1:0]  count;

  logic [3*DATA_W-1:0] sb[$];
  logic [3*DATA_W-1:0] exp_e;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_decode_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Flush       (Flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Instruction (Instruction),
    .Next_PC     (Next_PC),
    .IN_Port     (IN_Port),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Opcode      (Opcode),
    .Read_Reg_1  (Read_Reg_1),
    .Read_Reg_2  (Read_Reg_2),
    .Imm         (Imm),
    .Next_PC_out (Next_PC_out),
    .IN_Port_out (IN_Port_out),
    .count       (count)
  );

  task automatic drive_push(input logic [7:0] i, input logic [7:0] n,
                            input logic [7:0] p, input bit expect_accept);
    in_valid    = 1'b1;
    Instruction = i;
    Next_PC     = n;
    IN_Port     = p;
    if (expect_accept) sb.push_back({i, n, p});
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (count !== 3'd0) begin
      failures++; $display("FAIL rst_count got=%0d exp=0", count);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (Opcode !== 4'h0 || Imm !== 8'h00) begin
      failures++; $display("FAIL rst_data got=%h/%h exp=0/00", Opcode, Imm);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle got=%0d/%b/%b exp=0/0/1", count, out_valid, in_ready);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    drive_push(8'hA7, 8'h05, 8'h3C, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd1 || out_valid !== 1'b1) begin
      failures++; $display("FAIL single_cnt got=%0d/%b exp=1/1", count, out_valid);
    end
    checks++;
    if (Opcode !== 4'hA || Read_Reg_1 !== 2'd1 || Read_Reg_2 !== 2'd3) begin
      failures++;
      $display("FAIL single_dec got=%h/%0d/%0d exp=a/1/3", Opcode, Read_Reg_1, Read_Reg_2);
    end
    checks++;
    if (Imm !== 8'hA7 || Next_PC_out !== 8'h05 || IN_Port_out !== 8'h3C) begin
      failures++;
      $display("FAIL single_fld got=%h/%h/%h exp=a7/05/3c", Imm, Next_PC_out, IN_Port_out);
    end
    out_ready = 1'b1;
    exp_e = sb.pop_front();
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || Opcode !== 4'h0) begin
      failures++;
      $display("FAIL single_drain got=%0d/%b/%h exp=0/0/0", count, out_valid, Opcode);
    end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL full_fill_rdy%0d got=%b exp=1", i, in_ready);
      end
      drive_push(8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 1'b1);
      @(negedge clk);
    end
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      failures++; $display("FAIL full_state got=%0d/%b exp=4/0", count, in_ready);
    end
    drive_push(8'h99, 8'h99, 8'h99, 1'b0);
    @(negedge clk);
    checks++;
    if (count !== 3'd4) begin
      failures++; $display("FAIL full_5th got=%0d exp=4", count);
    end
    // pop while full with in_valid held: no push may sneak in
    out_ready = 1'b1;
    exp_e = sb.pop_front();
    checks++;
    if ({Imm, Next_PC_out, IN_Port_out} !== exp_e) begin
      failures++; $display("FAIL full_pop0 got=%h exp=%h", {Imm, Next_PC_out, IN_Port_out}, exp_e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd3) begin
      failures++; $display("FAIL full_pop_nopush got=%0d exp=3", count);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL full_sb_empty got=0 exp=entry");
      end else begin
        exp_e = sb.pop_front();
        if ({Imm, Next_PC_out, IN_Port_out} !== exp_e || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL full_drain%0d got=%h exp=%h", i, {Imm, Next_PC_out, IN_Port_out}, exp_e);
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || sb.size() != 0) begin
      failures++; $display("FAIL full_end got=%b/%0d exp=0/0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(8'(8'h50 + i), 8'(8'h70 + i), 8'(8'hF0 - i), 1'b1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (count !== 3'd3 || in_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_cnt%0d got=%0d/%b exp=3/1", k, count, in_ready);
      end
      exp_e = sb.pop_front();
      checks++;
      if ({Imm, Next_PC_out, IN_Port_out} !== exp_e) begin
        failures++;
        $display("FAIL b2b_head%0d got=%h exp=%h", k, {Imm, Next_PC_out, IN_Port_out}, exp_e);
      end
      drive_push(8'(8'h60 + k), 8'(8'h90 + k), 8'(8'h0F + k), 1'b1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_e = sb.pop_front();
      checks++;
      if ({Imm, Next_PC_out, IN_Port_out} !== exp_e) begin
        failures++;
        $display("FAIL b2b_drain%0d got=%h exp=%h", k, {Imm, Next_PC_out, IN_Port_out}, exp_e);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      failures++; $display("FAIL b2b_end got=%0d exp=0", count);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    drive_push(8'h80, 8'h01, 8'hE0, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (count !== 3'd1) begin
        failures++; $display("FAIL stream_cnt%0d got=%0d exp=1", k, count);
      end
      exp_e = sb.pop_front();
      checks++;
      if ({Imm, Next_PC_out, IN_Port_out} !== exp_e || Opcode !== exp_e[23:20]
          || Read_Reg_1 !== exp_e[19:18] || Read_Reg_2 !== exp_e[17:16]) begin
        failures++;
        $display("FAIL stream_head%0d got=%h op=%h exp=%h", k,
                 {Imm, Next_PC_out, IN_Port_out}, Opcode, exp_e);
      end
      drive_push(8'(8'h81 + k * 8'h13), 8'(8'h02 + k), 8'(8'hE1 + k), 1'b1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    exp_e = sb.pop_front();
    checks++;
    if ({Imm, Next_PC_out, IN_Port_out} !== exp_e) begin
      failures++; $display("FAIL stream_last got=%h exp=%h", {Imm, Next_PC_out, IN_Port_out}, exp_e);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL stream_end got=%0d/%b exp=0/0", count, out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(8'(8'hC0 + i), 8'(8'hB0 + i), 8'(8'hA0 + i), 1'b1);
      @(negedge clk);
    end
    checks++;
    if (count !== 3'd3) begin
      failures++; $display("FAIL flush_pre got=%0d exp=3", count);
    end
    Flush = 1'b1;
    out_ready = 1'b1;
    drive_push(8'hEE, 8'hEE, 8'hEE, 1'b0);
    @(negedge clk);
    Flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_state got=%0d/%b/%b exp=0/0/1", count, out_valid, in_ready);
    end
    checks++;
    if (Opcode !== 4'h0 || Imm !== 8'h00 || Next_PC_out !== 8'h00
        || IN_Port_out !== 8'h00 || Read_Reg_1 !== 2'd0 || Read_Reg_2 !== 2'd0) begin
      failures++;
      $display("FAIL flush_bubble got=%h/%h/%h/%h exp=0/00/00/00",
               Opcode, Imm, Next_PC_out, IN_Port_out);
    end
    @(negedge clk);
    checks++;
    if (count !== 3'd0) begin
      failures++; $display("FAIL flush_lost got=%0d exp=0", count);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_push(8'hD0, 8'h11, 8'h22, 1'b1);
    @(negedge clk);
    drive_push(8'hD1, 8'h12, 8'h23, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd2 || Imm !== 8'hD0) begin
      failures++; $display("FAIL rmid_pre got=%0d/%h exp=2/d0", count, Imm);
    end
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || Imm !== 8'h00 || Opcode !== 4'h0 || count !== 3'd0) begin
      failures++;
      $display("FAIL rmid_async got=%b/%h/%h/%0d exp=0/00/0/0", out_valid, Imm, Opcode, count);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_after got=%0d/%b/%b exp=0/1/0", count, in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_stream();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

Interface
REQ-001 Parameter DATA_W, default 8: instruction, Next_PC and IN_Port width, in bits.
REQ-002 Parameter DEPTH, default 4: entry count; power of two, >=2.
REQ-003 Parameter CNT_W, default $clog2(DEPTH+1): width of the occupancy count.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 Flush  input  1  synchronous discard of all queued entries.
REQ-007 in_valid  input  1  fetch side presents an entry.
REQ-008 in_ready  output  1  queue accepts an entry this cycle.
REQ-009 Instruction  input  DATA_W  fetched instruction.
REQ-010 Next_PC  input  DATA_W  PC+1 of the fetched instruction.
REQ-011 IN_Port  input  DATA_W  input-port sample taken with the instruction.
REQ-012 out_valid  output  1  head entry is valid.
REQ-013 out_ready  input  1  decode consumes the head entry (the stall is the inverse).
REQ-014 Opcode  output  4  head Instruction[DATA_W-1:DATA_W-4].
REQ-015 Read_Reg_1  output  2  head Instruction[3:2].
REQ-016 Read_Reg_2  output  2  head Instruction[1:0].
REQ-017 Imm  output  DATA_W  full head instruction word.
REQ-018 Next_PC_out  output  DATA_W  head Next_PC.
REQ-019 IN_Port_out  output  DATA_W  head IN_Port.
REQ-020 count  output  CNT_W  current occupancy, 0..DEPTH.

Function
REQ-021 Push SHALL occur when in_valid && in_ready && !Flush; push writes {Instruction, Next_PC, IN_Port} at the write pointer.
REQ-022 Pop SHALL occur when out_valid && out_ready && !Flush; pop advances the read pointer.
REQ-023 in_ready SHALL be (count < DEPTH) and SHALL be derived from registered state only, with no combinational path from out_ready.
REQ-024 out_valid SHALL be (count != 0).
REQ-025 Latency: an entry pushed at edge N SHALL appear on the outputs with out_valid=1 after edge N; there is no same-cycle fall-through.
REQ-026 Data outputs SHALL be driven combinationally from the head entry while out_valid=1.
REQ-027 While out_valid=0, all data outputs SHALL be 0, so the stage presents a NOP bubble (opcode 0).
REQ-028 A simultaneous push and pop SHALL leave count unchanged and advance both pointers; this is legal at any count below DEPTH.
REQ-029 When full (count=DEPTH), in_ready=0 and no push occurs, even if a pop happens in that cycle.
REQ-030 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-031 Flush SHALL set pointers and count to 0 at the next edge and SHALL override any push or pop in the same cycle; outputs SHALL be bubble (all zero) in the following cycle.
REQ-032 Entries SHALL leave in FIFO order, with field grouping preserved per entry.

Reset
REQ-033 While rst=0: pointers=0, count=0, out_valid=0, in_ready=1, all data outputs 0, applied immediately without waiting for clk.
REQ-034 Storage array contents need not be reset, because outputs are masked by REQ-027.
REQ-035 Deassertion of rst is synchronised externally; a reset mid-operation discards all entries.

Structure
REQ-036 Shared package SHALL hold: opcode field width (4), register-address width (2), field bit positions, and the NOP opcode constant (0).
REQ-037 One sub-module, queue_ptr, SHALL implement a wrap-around pointer with increment and clear, instantiated for read and for write.
REQ-038 The storage array and count SHALL stay in fetch_decode_queue.

Verification
REQ-039 Reset then idle: count=0, out_valid=0, in_ready=1, Opcode=0, Imm=0.
REQ-040 Push 0xA7/Next_PC 0x05/IN_Port 0x3C, out_ready=0: next cycle Opcode=0xA, Read_Reg_1=1, Read_Reg_2=3, Imm=0xA7, Next_PC_out=0x05, IN_Port_out=0x3C, count=1.
REQ-041 Push 4 entries (0x10..0x13) with out_ready=0: count=4, in_ready=0; a 5th push is ignored. Drain with out_ready=1: 0x10,0x11,0x12,0x13 in order, then out_valid=0.
REQ-042 Continuous push and pop for 10 cycles: count stays 1, pointers wrap, every word seen once in order.
REQ-043 Count=3, Flush=1 with in_valid=1 and out_ready=1 in the same cycle: next cycle count=0, outputs zero, pushed word lost.
REQ-044 Assert rst mid-stream with count=2: outputs zero immediately, and after release count=0.
